// File: rtl/xcom_cmd_queue.sv
// Command FIFO that replays queued core commands over the xcom local/network 4-phase req/ack link.
// Optional macro XCOM_CMDQ_CNT_EN enables the completed-command counter on cmd_cnt_o.
module xcom_cmd_queue #(
  parameter int AW     = 3,
  parameter int TOUT_W = 10
) (
  input  logic          c_clk_i,
  input  logic          c_rst_i,
  input  logic          core_en_i,
  input  logic          core_loc_i,
  input  logic [7:0]    core_op_i,
  input  logic [31:0]   core_dt_i,
  output logic          core_rdy_o,
  output logic          cmd_loc_req_o,
  input  logic          cmd_loc_ack_i,
  output logic          cmd_net_req_o,
  input  logic          cmd_net_ack_i,
  output logic [7:0]    cmd_op_o,
  output logic [31:0]   cmd_dt_o,
  input  logic          clr_i,
  output logic [AW:0]   q_cnt_o,
  output logic          q_empty_o,
  output logic          q_full_o,
  output logic          busy_o,
  output logic          ovf_o,
  output logic          tout_o,
  output logic [15:0]   cmd_cnt_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [TOUT_W-1:0] TCNT_ONE = {{(TOUT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  logic [40:0]       mem [DEPTH];
  logic [40:0]       head;

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic              loc_sel_q, loc_sel_d;
  logic              loc_req_q, loc_req_d;
  logic              net_req_q, net_req_d;
  logic [7:0]        op_q, op_d;
  logic [31:0]       dt_q, dt_d;
  logic [TOUT_W-1:0] tcnt_q, tcnt_d;
  logic              ovf_q, ovf_d;
  logic              tout_q, tout_d;
  logic [1:0]        net_sync_q, net_sync_d;

  logic full, empty, wr_acc, pop, ack_sel, tout_hit, tout_set;

  // Network ack comes from the x_clk domain; only its synchronized copy is ever used.
  always_comb begin
    net_sync_d = {net_sync_q[0], cmd_net_ack_i};
  end

  always_comb begin
    head     = mem[rd_ptr_q[AW-1:0]];
    full     = (cnt_q == FULL_CNT);
    empty    = (cnt_q == '0);
    wr_acc   = core_en_i & ~full;
    pop      = (state_q == ST_IDLE) & ~empty;
    ack_sel  = loc_sel_q ? cmd_loc_ack_i : net_sync_q[1];
    tout_hit = &tcnt_q;

    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({wr_acc, pop})
      2'b10:   cnt_d = cnt_q + PTR_ONE;
      2'b01:   cnt_d = cnt_q - PTR_ONE;
      default: cnt_d = cnt_q;
    endcase

    state_d   = state_q;
    loc_sel_d = loc_sel_q;
    loc_req_d = 1'b0;
    net_req_d = 1'b0;
    op_d      = op_q;
    dt_d      = dt_q;
    tout_set  = 1'b0;

    // Req is raised one cycle after the pop so op/dt are settled before the
    // request edge reaches the (possibly asynchronous) receiver.
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d   = ST_REQ;
          loc_sel_d = head[40];
          op_d      = head[39:32];
          dt_d      = head[31:0];
        end
      end
      ST_REQ: begin
        if ((loc_req_q | net_req_q) & ack_sel) begin
          state_d = ST_REL;
        end else if (tout_hit) begin
          state_d  = ST_REL;
          tout_set = 1'b1;
        end else begin
          loc_req_d = loc_sel_q;
          net_req_d = ~loc_sel_q;
        end
      end
      ST_REL: begin
        if (!ack_sel) begin
          state_d = ST_IDLE;
        end else if (tout_hit) begin
          state_d  = ST_IDLE;
          tout_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      tcnt_d = '0;
    end else if (state_q != ST_IDLE) begin
      tcnt_d = tcnt_q + TCNT_ONE;
    end else begin
      tcnt_d = '0;
    end

    // Set events take priority over a coincident clear.
    ovf_d  = (ovf_q & ~clr_i) | (core_en_i & full);
    tout_d = (tout_q & ~clr_i) | tout_set;
  end

  always_ff @(posedge c_clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= {core_loc_i, core_op_i, core_dt_i};
    end
  end

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      loc_sel_q  <= 1'b0;
      loc_req_q  <= 1'b0;
      net_req_q  <= 1'b0;
      op_q       <= '0;
      dt_q       <= '0;
      tcnt_q     <= '0;
      ovf_q      <= 1'b0;
      tout_q     <= 1'b0;
      net_sync_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      loc_sel_q  <= loc_sel_d;
      loc_req_q  <= loc_req_d;
      net_req_q  <= net_req_d;
      op_q       <= op_d;
      dt_q       <= dt_d;
      tcnt_q     <= tcnt_d;
      ovf_q      <= ovf_d;
      tout_q     <= tout_d;
      net_sync_q <= net_sync_d;
    end
  end

`ifdef XCOM_CMDQ_CNT_EN
  logic [15:0] cmd_cnt_q, cmd_cnt_d;

  always_comb begin
    cmd_cnt_d = cmd_cnt_q;
    if ((state_q == ST_REL) && (state_d == ST_IDLE) && (cmd_cnt_q != 16'hFFFF)) begin
      cmd_cnt_d = cmd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      cmd_cnt_q <= '0;
    end else begin
      cmd_cnt_q <= cmd_cnt_d;
    end
  end

  assign cmd_cnt_o = cmd_cnt_q;
`else
  assign cmd_cnt_o = 16'h0000;
`endif

  assign core_rdy_o    = ~full;
  assign cmd_loc_req_o = loc_req_q;
  assign cmd_net_req_o = net_req_q;
  assign cmd_op_o      = op_q;
  assign cmd_dt_o      = dt_q;
  assign q_cnt_o       = cnt_q;
  assign q_empty_o     = empty;
  assign q_full_o      = full;
  assign busy_o        = (state_q != ST_IDLE);
  assign ovf_o         = ovf_q;
  assign tout_o        = tout_q;

endmodule
